// File: rtl/feature_weight_transform_if.sv
// Handshake/memory bundle for feature_weight_transform.
// master = transform engine, slave = memories, FM_WM buffer and controller.
`timescale 1ns/1ps
interface feature_weight_transform_if #(
    parameter int ROW_BW    = 1,
    parameter int FEAT_BW   = 1,
    parameter int COL_BW    = 1,
    parameter int FM_WIDTH  = 5,
    parameter int WM_WIDTH  = 5,
    parameter int ACC_WIDTH = 16
);
    logic                 start;
    logic                 read_en;
    logic [ROW_BW-1:0]    fm_row_addr;
    logic [FEAT_BW-1:0]   fm_col_addr;
    logic [FEAT_BW-1:0]   wm_row_addr;
    logic [COL_BW-1:0]    wm_col_addr;
    logic [FM_WIDTH-1:0]  fm_data;
    logic [WM_WIDTH-1:0]  wm_data;
    logic                 fm_wm_wr_en;
    logic [ROW_BW-1:0]    fm_wm_row;
    logic [COL_BW-1:0]    fm_wm_col;
    logic [ACC_WIDTH-1:0] fm_wm_data;
    logic                 done;

    modport master (
        input  start, fm_data, wm_data,
        output read_en, fm_row_addr, fm_col_addr,
        output wm_row_addr, wm_col_addr,
        output fm_wm_wr_en, fm_wm_row, fm_wm_col,
        output fm_wm_data, done
    );

    modport slave (
        output start, fm_data, wm_data,
        input  read_en, fm_row_addr, fm_col_addr,
        input  wm_row_addr, wm_col_addr,
        input  fm_wm_wr_en, fm_wm_row, fm_wm_col,
        input  fm_wm_data, done
    );
endinterface

// File: rtl/feature_weight_transform.sv
// Dense FM x WM transform, one MAC per two cycles, row-major FM_WM writes.
// Define ACC_SATURATE_EN to clamp the accumulator instead of wrapping.
`timescale 1ns/1ps
module feature_weight_transform #(
    parameter int FEATURE_ROWS = 6,
    parameter int FEATURE_COLS = 96,
    parameter int WEIGHT_COLS  = 3,
    parameter int FM_WIDTH     = 5,
    parameter int WM_WIDTH     = 5,
    parameter int ACC_WIDTH    = 16,
    localparam int ROW_BW  = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1,
    localparam int FEAT_BW = (FEATURE_COLS > 1) ? $clog2(FEATURE_COLS) : 1,
    localparam int COL_BW  = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1
) (
    input logic                      clk,
    input logic                      reset,
    feature_weight_transform_if.master bus
);
    localparam int PW = FM_WIDTH + WM_WIDTH;

    typedef enum logic [2:0] {
        IDLE, CLEAR, READ, MAC, WRITE, DONE
    } state_e;

    state_e               state_q, state_d;
    logic [ROW_BW-1:0]    row_q, row_d;
    logic [COL_BW-1:0]    col_q, col_d;
    logic [FEAT_BW-1:0]   k_q, k_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] mac_acc;
    logic [PW-1:0]        prod;
    logic                 last_k, last_col, last_row;

    assign prod     = PW'(bus.fm_data) * PW'(bus.wm_data);
    assign last_k   = (k_q == FEAT_BW'(FEATURE_COLS - 1));
    assign last_col = (col_q == COL_BW'(WEIGHT_COLS - 1));
    assign last_row = (row_q == ROW_BW'(FEATURE_ROWS - 1));

`ifdef ACC_SATURATE_EN
    localparam int SW = ((ACC_WIDTH > PW) ? ACC_WIDTH : PW) + 1;
    logic [SW-1:0] sum;
    // Any carry above ACC_WIDTH means the true sum no longer fits.
    always_comb begin
        sum     = SW'(acc_q) + SW'(prod);
        mac_acc = sum[ACC_WIDTH-1:0];
        if (|sum[SW-1:ACC_WIDTH]) mac_acc = '1;
    end
`else
    assign mac_acc = acc_q + ACC_WIDTH'(prod);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            k_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        k_d     = k_q;
        acc_d   = acc_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CLEAR;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            CLEAR: begin
                acc_d   = '0;
                k_d     = '0;
                state_d = READ;
            end
            READ: state_d = MAC;
            MAC: begin
                acc_d = mac_acc;
                if (last_k) begin
                    state_d = WRITE;
                end else begin
                    k_d     = k_q + FEAT_BW'(1);
                    state_d = READ;
                end
            end
            WRITE: begin
                if (last_col && last_row) begin
                    state_d = DONE;
                end else if (last_col) begin
                    col_d   = '0;
                    row_d   = row_q + ROW_BW'(1);
                    state_d = CLEAR;
                end else begin
                    col_d   = col_q + COL_BW'(1);
                    state_d = CLEAR;
                end
            end
            DONE: begin
                if (!bus.start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.read_en     = (state_q == READ);
    assign bus.fm_wm_wr_en = (state_q == WRITE);
    assign bus.done        = (state_q == DONE);
    assign bus.fm_row_addr = row_q;
    assign bus.fm_col_addr = k_q;
    assign bus.wm_row_addr = k_q;
    assign bus.wm_col_addr = col_q;
    assign bus.fm_wm_row   = row_q;
    assign bus.fm_wm_col   = col_q;
    assign bus.fm_wm_data  = acc_q;
endmodule

// File: tb/tb_feature_weight_transform.sv
// Bench for feature_weight_transform: R=2 F=3 C=2 main DUT plus an 8-bit
// accumulator DUT for overflow behaviour.
`timescale 1ns/1ps
module tb_feature_weight_transform;
    localparam int R = 2, F = 3, C = 2;
    localparam int RB = 1, FB = 2, CB = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    feature_weight_transform_if #(.ROW_BW(RB), .FEAT_BW(FB), .COL_BW(CB),
        .FM_WIDTH(5), .WM_WIDTH(5), .ACC_WIDTH(16)) mb ();
    feature_weight_transform_if #(.ROW_BW(RB), .FEAT_BW(FB), .COL_BW(CB),
        .FM_WIDTH(5), .WM_WIDTH(5), .ACC_WIDTH(8)) nb ();

    feature_weight_transform #(.FEATURE_ROWS(R), .FEATURE_COLS(F),
        .WEIGHT_COLS(C), .FM_WIDTH(5), .WM_WIDTH(5), .ACC_WIDTH(16)) dut (
        .clk(clk), .reset(rst_n), .bus(mb.master));
    feature_weight_transform #(.FEATURE_ROWS(R), .FEATURE_COLS(F),
        .WEIGHT_COLS(C), .FM_WIDTH(5), .WM_WIDTH(5), .ACC_WIDTH(8)) dut_n (
        .clk(clk), .reset(rst_n), .bus(nb.master));

    logic [4:0] fm_mem [R][F];
    logic [4:0] wm_mem [F][C];

    // One-cycle read latency memories
    always @(posedge clk) begin
        if (mb.read_en) begin
            mb.fm_data <= fm_mem[mb.fm_row_addr][mb.fm_col_addr];
            mb.wm_data <= wm_mem[mb.wm_row_addr][mb.wm_col_addr];
        end
        if (nb.read_en) begin
            nb.fm_data <= 5'd31;
            nb.wm_data <= 5'd31;
        end
    end

    typedef struct { int r; int c; int d; } exp_t;
    exp_t q[$];
    exp_t me;
    int   wr_cyc[$];
    int   nq[$];
    int   n_wr = 0;
    int   nd;

    always @(negedge clk) begin
        if (mb.fm_wm_wr_en) begin
            checks++;
            wr_cyc.push_back(cyc);
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write row=%0d col=%0d data=%0d",
                         mb.fm_wm_row, mb.fm_wm_col, mb.fm_wm_data);
            end else begin
                me = q.pop_front();
                if (int'(mb.fm_wm_row) !== me.r || int'(mb.fm_wm_col) !== me.c ||
                    int'(mb.fm_wm_data) !== me.d) begin
                    errors++;
                    $display("FAIL write got=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)",
                             mb.fm_wm_row, mb.fm_wm_col, mb.fm_wm_data,
                             me.r, me.c, me.d);
                end
            end
        end
        if (nb.fm_wm_wr_en) begin
            checks++;
            n_wr++;
            if (nq.size() == 0) begin
                errors++;
                $display("FAIL narrow_unexpected data=%0d", nb.fm_wm_data);
            end else begin
                nd = nq.pop_front();
                if (int'(nb.fm_wm_data) !== nd) begin
                    errors++;
                    $display("FAIL narrow_write got=%0d exp=%0d",
                             nb.fm_wm_data, nd);
                end
            end
        end
    end

    task automatic push_model();
        int s;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                s = 0;
                for (int k = 0; k < F; k++)
                    s += int'(fm_mem[r][k]) * int'(wm_mem[k][c]);
                q.push_back('{r, c, s % 65536});
            end
    endtask

    task automatic fill_const(input int fv, input int wv);
        for (int r = 0; r < R; r++)
            for (int k = 0; k < F; k++) fm_mem[r][k] = 5'(fv);
        for (int k = 0; k < F; k++)
            for (int c = 0; c < C; c++) wm_mem[k][c] = 5'(wv);
    endtask

    task automatic pulse_start(output int clr);
        @(negedge clk);
        mb.start = 1'b1;
        @(negedge clk);
        mb.start = 1'b0;
        clr = cyc;
    endtask

    task automatic wait_done(input string nm, output int at);
        at = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mb.done) begin
                at = cyc;
                break;
            end
        end
        checks++;
        if (at < 0) begin
            errors++;
            $display("FAIL %s_timeout done=0 exp=1", nm);
        end
    endtask

    task automatic check_run_end(input string nm);
        checks++;
        if (q.size() != 0 || wr_cyc.size() != 4) begin
            errors++;
            $display("FAIL %s_writes left=%0d seen=%0d exp_left=0 exp_seen=4",
                     nm, q.size(), wr_cyc.size());
        end
    endtask

    task automatic test_reset();
        mb.start = 1'b0;
        nb.start = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({mb.read_en, mb.fm_wm_wr_en, mb.done, mb.fm_row_addr,
             mb.fm_col_addr, mb.wm_row_addr, mb.wm_col_addr,
             mb.fm_wm_row, mb.fm_wm_col, mb.fm_wm_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%0d,%0d,%0d data=%0d exp=all 0",
                     mb.read_en, mb.fm_wm_wr_en, mb.done, mb.fm_wm_data);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({mb.read_en, mb.fm_wm_wr_en, mb.done} !== 3'b000) begin
            errors++;
            $display("FAIL idle_strobes got=%b exp=000",
                     {mb.read_en, mb.fm_wm_wr_en, mb.done});
        end
    endtask

    task automatic test_ones_timing();
        int clr, dat;
        fill_const(1, 2);
        wr_cyc.delete();
        push_model();
        pulse_start(clr);
        wait_done("ones", dat);
        check_run_end("ones");
        checks++;
        if (dat - clr != 32) begin
            errors++;
            $display("FAIL done_latency got=%0d exp=32", dat - clr);
        end
        if (wr_cyc.size() == 4) begin
            checks++;
            if (wr_cyc[0] - clr != 7) begin
                errors++;
                $display("FAIL first_write got=%0d exp=7", wr_cyc[0] - clr);
            end
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (wr_cyc[i] - wr_cyc[i-1] != 8) begin
                    errors++;
                    $display("FAIL write_gap%0d got=%0d exp=8",
                             i, wr_cyc[i] - wr_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_pattern();
        int clr, dat;
        for (int r = 0; r < R; r++)
            for (int k = 0; k < F; k++) fm_mem[r][k] = 5'(r * 3 + k + 1);
        for (int k = 0; k < F; k++) begin
            wm_mem[k][0] = (k != 1) ? 5'd1 : 5'd0;
            wm_mem[k][1] = (k == 1) ? 5'd1 : 5'd0;
        end
        wr_cyc.delete();
        push_model();
        pulse_start(clr);
        wait_done("pattern", dat);
        check_run_end("pattern");
    endtask

    task automatic test_wrap();
        int exp_d, got;
`ifdef ACC_SATURATE_EN
        exp_d = 255;
`else
        exp_d = 67;
`endif
        n_wr = 0;
        for (int i = 0; i < 4; i++) nq.push_back(exp_d);
        @(negedge clk);
        nb.start = 1'b1;
        @(negedge clk);
        nb.start = 1'b0;
        got = 0;
        for (int i = 0; i < 200 && !nb.done; i++) @(negedge clk);
        checks++;
        if (nb.done !== 1'b1 || n_wr != 4 || nq.size() != 0) begin
            errors++;
            $display("FAIL narrow_run done=%b writes=%0d left=%0d exp=1,4,0",
                     nb.done, n_wr, nq.size());
        end
    endtask

    task automatic test_reset_midrun();
        int clr, dat;
        fill_const(1, 2);
        wr_cyc.delete();
        push_model();
        pulse_start(clr);
        repeat (10) @(negedge clk);
        checks++;
        if (wr_cyc.size() != 1 || mb.read_en !== 1'b0) begin
            errors++;
            $display("FAIL midrun_position writes=%0d read_en=%b exp=1,0",
                     wr_cyc.size(), mb.read_en);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mb.read_en, mb.fm_wm_wr_en, mb.done, mb.fm_row_addr,
             mb.fm_col_addr, mb.wm_col_addr, mb.fm_wm_col,
             mb.fm_wm_data} !== '0) begin
            errors++;
            $display("FAIL async_reset data=%0d col=%0d exp=0,0",
                     mb.fm_wm_data, mb.fm_wm_col);
        end
        q.delete();
        repeat (20) @(negedge clk);
        checks++;
        if (wr_cyc.size() != 1) begin
            errors++;
            $display("FAIL writes_after_reset got=%0d exp=1", wr_cyc.size());
        end
        rst_n = 1'b1;
        @(negedge clk);
        wr_cyc.delete();
        push_model();
        pulse_start(clr);
        wait_done("restart", dat);
        check_run_end("restart");
    endtask

    task automatic test_hold_start();
        int dat, low, clr;
        fill_const(3, 5);
        wr_cyc.delete();
        push_model();
        @(negedge clk);
        mb.start = 1'b1;
        wait_done("hold", dat);
        check_run_end("hold");
        low = 0;
        repeat (20) begin
            @(negedge clk);
            if (mb.done !== 1'b1) low++;
        end
        checks++;
        if (low != 0 || wr_cyc.size() != 4) begin
            errors++;
            $display("FAIL hold_done low_cycles=%0d writes=%0d exp=0,4",
                     low, wr_cyc.size());
        end
        mb.start = 1'b0;
        @(negedge clk);
        checks++;
        if (mb.done !== 1'b0) begin
            errors++;
            $display("FAIL done_clear got=%b exp=0", mb.done);
        end
        wr_cyc.delete();
        push_model();
        pulse_start(clr);
        wait_done("rerun", dat);
        check_run_end("rerun");
    endtask

    initial begin
        test_reset();
        test_ones_timing();
        test_pattern();
        test_wrap();
        test_reset_midrun();
        test_hold_start();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/feature_weight_transform.md
# feature_weight_transform

Computes the dense transform FM×WM (node feature matrix times weight matrix) that precedes COO edge aggregation in the GCN pipeline. It reads feature and weight memories element by element and accumulates each dot product. Each finished FM_WM[row][col] element is written into the FM_WM buffer. When `done` asserts, the FM_WM buffer is complete and the downstream aggregation FSM may be started.

## Interface
- `FEATURE_ROWS`, default 6: number of nodes (rows of FM and FM_WM)
- `FEATURE_COLS`, default 96: feature length (FM columns = WM rows); dot-product length
- `WEIGHT_COLS`, default 3: WM columns = FM_WM columns
- `FM_WIDTH`, default 5: unsigned feature element width
- `WM_WIDTH`, default 5: unsigned weight element width
- `ACC_WIDTH`, default 16: accumulator / FM_WM element width
- Derived widths: `ROW_BW`, `FEAT_BW`, `COL_BW` = max(1, $clog2(N)) of the respective dimension

Ports:
- `clk` in 1: clock, all state on rising edge
- `reset` in 1: asynchronous, active-low; low clears all state immediately
- `start` in 1: level request; sampled in IDLE and DONE
- `read_en` out 1: read strobe to FM and WM memories
- `fm_row_addr` out ROW_BW: FM row (node)
- `fm_col_addr` out FEAT_BW: FM column (feature k)
- `wm_row_addr` out FEAT_BW: WM row (feature k)
- `wm_col_addr` out COL_BW: WM column
- `fm_data` in FM_WIDTH: FM read data, valid the cycle after `read_en`
- `wm_data` in WM_WIDTH: WM read data, valid the cycle after `read_en`
- `fm_wm_wr_en` out 1: write strobe to FM_WM buffer
- `fm_wm_row` out ROW_BW, `fm_wm_col` out COL_BW: write address
- `fm_wm_data` out ACC_WIDTH: write data (accumulator)
- `done` out 1: transform complete

## Operation
- Counters: `row` (0..FEATURE_ROWS-1), `col` (0..WEIGHT_COLS-1), `k` (0..FEATURE_COLS-1). Accumulator `acc` is ACC_WIDTH bits.
- Outputs are decoded from state only; there are no combinational paths from inputs to outputs.
- Address outputs are fed from the counters: FM addr = (row, k), WM addr = (k, col), FM_WM addr = (row, col).
- State machine:
  - IDLE: all strobes 0. If `start` is 1, go to CLEAR and zero row and col.
  - CLEAR: acc←0, k←0, then go to READ.
  - READ: `read_en`=1, then go to MAC.
  - MAC: acc←acc + fm_data×wm_data, with the product FM_WIDTH+WM_WIDTH bits wide and zero-extended. If k==FEATURE_COLS-1, go to WRITE; otherwise k←k+1 and go to READ.
  - WRITE: `fm_wm_wr_en`=1 with `fm_wm_data`=acc. Then advance:
    - col==WEIGHT_COLS-1 and row==FEATURE_ROWS-1: go to DONE.
    - col==WEIGHT_COLS-1 otherwise: col←0, row←row+1, go to CLEAR.
    - otherwise: col←col+1, go to CLEAR.
  - DONE: `done`=1. Stay while `start`=1; go to IDLE when `start`=0. Counters are then re-zeroed on the next start.
- Write order is row-major: (0,0), (0,1), …, (R-1,C-1), each element written exactly once.
- Default arithmetic wraps modulo 2^ACC_WIDTH.
- `start` toggling mid-run is ignored; the run always completes.
- Reset low at any time forces IDLE, counters 0, acc 0, all outputs 0. No partial write is issued.

## Timing
- Reset values: all outputs 0; `done`=0; state IDLE.
- Cycles per element: 2·FEATURE_COLS + 2 (CLEAR, READ/MAC pairs, WRITE).
- `start` high on edge N gives CLEAR in cycle N+1. The first `read_en` is at N+2.
- First `fm_wm_wr_en` is at N+1+2F+1.
- `done` first asserts R·C·(2F+2) cycles after the cycle in which CLEAR is first entered.
- Memory read latency is exactly 1 cycle: data driven in the cycle after READ is consumed in MAC.
- `fm_wm_wr_en` is a single-cycle pulse per element; at least 2F+1 cycles separate consecutive pulses.

## Configuration
- `ACC_SATURATE_EN` defined: MAC clamps `acc` at 2^ACC_WIDTH-1 on overflow and holds it there for the rest of that element.
- `ACC_SATURATE_EN` undefined: the accumulator wraps modulo 2^ACC_WIDTH.
- Neither mode affects cycle timing.

## Test plan
- Test parameters: R=2, F=3, C=2, defaults otherwise.
- All FM=1, all WM=2, start pulsed high → four writes in order (0,0), (0,1), (1,0), (1,1). Each write has data 6 and pulses 8 cycles apart. `done` goes high 32 cycles after CLEAR entry.
- FM row0=[1,2,3], row1=[4,5,6]; WM col0=[1,0,1], col1=[0,1,0] → writes 4, 2, 10, 5.
- ACC_WIDTH=8, all FM=31, all WM=31 → written data is 67 without the macro (2883 mod 256) and 255 with `ACC_SATURATE_EN`.
- Reset driven low during the second element's MAC → outputs go 0 immediately and no further writes occur. Restart gives the full 4-write sequence from (0,0).
- `start` held high through DONE → `done` stays 1 and no rerun happens. `start` low then high → `done` clears and a complete second run produces identical writes.
